// File: rtl/if_stage_unit.sv
// if_stage_unit: instruction-fetch stage.
// Owns the PC, presents it to the combinational instruction memory and captures
// the returned word into the IF/ID register. An EX-stage taken branch redirects
// the PC and flushes IF/ID; a hazard freeze holds both.
// Optional performance counters are built when IF_PERF_CNT_EN is defined;
// otherwise fetch_cnt/flush_cnt read 0 and no counter registers exist.
module if_stage_unit #(
   parameter int              N        = 32,
   parameter logic [N-1:0]    RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          freeze,
   input  logic          branch_taken,
   input  logic [N-1:0]  branch_addr,
   output logic [N-1:0]  imem_adr,
   input  logic [N-1:0]  imem_instr,
   output logic [N-1:0]  id_pc,
   output logic [N-1:0]  id_instr,
   output logic          id_valid,
   output logic [N-1:0]  fetch_cnt,
   output logic [N-1:0]  flush_cnt
);

   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] pc_plus4;
   logic [N-1:0] br_target;
   logic [N-1:0] id_pc_q, id_pc_d;
   logic [N-1:0] id_instr_q, id_instr_d;
   logic         id_valid_q, id_valid_d;
   logic         load_en;

   // Word-align the branch target; the low two address bits never reach the PC.
   assign br_target = branch_addr & ~N'(3);
   assign pc_plus4  = pc_q + N'(4);
   assign load_en   = !branch_taken && !freeze;

   // Next-state selection: branch beats freeze beats sequential fetch.
   always_comb begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      if (branch_taken) begin
         pc_d       = br_target;
         id_pc_d    = '0;
         id_instr_d = '0;
         id_valid_d = 1'b0;
      end else if (!freeze) begin
         pc_d       = pc_plus4;
         id_pc_d    = pc_plus4;
         id_instr_d = imem_instr;
         id_valid_d = 1'b1;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   // IF/ID pipeline register; imem_instr is only sampled on a real load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_pc_q    <= '0;
         id_instr_q <= '0;
         id_valid_q <= 1'b0;
      end else begin
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign imem_adr = pc_q;
   assign id_pc    = id_pc_q;
   assign id_instr = id_instr_q;
   assign id_valid = id_valid_q;

`ifdef IF_PERF_CNT_EN
   logic [N-1:0] fetch_cnt_q, flush_cnt_q;

   // Performance counters: real IF/ID loads and taken-branch flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (load_en)      fetch_cnt_q <= fetch_cnt_q + N'(1);
         if (branch_taken) flush_cnt_q <= flush_cnt_q + N'(1);
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_load_en;
   assign unused_load_en = load_en;
   assign fetch_cnt      = '0;
   assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Bench for if_stage_unit: directed scenarios plus randomized branch/freeze
// traffic, checked against a cycle-level reference model of the fetch stage.
module tb_if_stage_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_adr;
   logic [31:0] imem_instr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;

   int vecs = 0;
   int errs = 0;

   // reference model state
   logic [31:0] m_pc, m_idpc, m_instr, m_fc, m_flc;
   logic        m_valid;

   if_stage_unit #(.N(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_adr(imem_adr), .imem_instr(imem_instr),
      .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
      .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // instruction memory contents: two fixed words, hashed data elsewhere
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      case (a)
         32'h0:   return 32'hE3A00014;
         32'h4:   return 32'hE3A01A01;
         default: return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
      endcase
   endfunction

   assign imem_instr = mem_f(imem_adr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_idpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_fc = 32'h0; m_flc = 32'h0;
   endtask

   task automatic check_all();
      chk("imem_adr", imem_adr, m_pc);
      chk("id_pc",    id_pc,    m_idpc);
      chk("id_instr", id_instr, m_instr);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fc);
      chk("flush_cnt", flush_cnt, m_flc);
`else
      chk("fetch_cnt", fetch_cnt, 32'h0);
      chk("flush_cnt", flush_cnt, 32'h0);
`endif
   endtask

   // one clock: drive inputs, advance the model, check after the edge
   task automatic step(input logic br, input logic [31:0] addr, input logic frz);
      branch_taken = br;
      branch_addr  = addr;
      freeze       = frz;
      if (br) begin
         m_pc    = {addr[31:2], 2'b00};
         m_idpc  = 32'h0;
         m_instr = 32'h0;
         m_valid = 1'b0;
         m_flc   = m_flc + 1;
      end else if (!frz) begin
         m_instr = mem_f(m_pc);
         m_idpc  = m_pc + 32'd4;
         m_pc    = m_pc + 32'd4;
         m_valid = 1'b1;
         m_fc    = m_fc + 1;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // sequential fetch from address 0
      step(1'b0, 32'h0, 1'b0);
      chk("seq0_pc",    id_pc,    32'd4);
      chk("seq0_instr", id_instr, 32'hE3A00014);
      step(1'b0, 32'h0, 1'b0);
      chk("seq1_pc",    id_pc,    32'd8);
      chk("seq1_instr", id_instr, 32'hE3A01A01);
      chk("seq1_adr",   imem_adr, 32'd8);

      // freeze two cycles at pc 8, then release
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("frz_adr",   imem_adr, 32'd8);
      chk("frz_instr", id_instr, 32'hE3A01A01);
      step(1'b0, 32'h0, 1'b0);
      chk("rel_adr", imem_adr, 32'd12);
      chk("rel_pc",  id_pc,    32'd12);

      // branch from 148 to 112
      step(1'b1, 32'd148, 1'b0);
      step(1'b1, 32'd112, 1'b0);
      chk("br_adr",   imem_adr, 32'd112);
      chk("br_valid", {31'b0, id_valid}, 32'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("br_idpc",  id_pc, 32'd116);
      chk("br_valid2", {31'b0, id_valid}, 32'd1);

      // branch beats freeze, unaligned target; PC wrap
      step(1'b1, 32'h71, 1'b1);
      chk("prio_adr", imem_adr, 32'h70);
      step(1'b1, 32'hFFFFFFFE, 1'b0);
      chk("top_adr", imem_adr, 32'hFFFFFFFC);
      step(1'b0, 32'h0, 1'b0);
      chk("wrap_adr",  imem_adr, 32'h0);
      chk("wrap_idpc", id_pc,    32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
         step($urandom_range(0, 7) == 0, a, $urandom_range(0, 3) == 0);
      end

      // asynchronous reset mid-branch/mid-freeze, between edges
      @(negedge clk);
      branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h40;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      branch_taken = 1'b0; freeze = 1'b0;
      #1;
      rst_n = 1'b1;

      // counter scenario: 10 loads, 1 freeze, 2 branches
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h200, 1'b0);
      step(1'b1, 32'h300, 1'b0);
`ifdef IF_PERF_CNT_EN
      chk("cnt_fetch", fetch_cnt, 32'd10);
      chk("cnt_flush", flush_cnt, 32'd2);
`else
      chk("cnt_fetch_off", fetch_cnt, 32'd0);
      chk("cnt_flush_off", flush_cnt, 32'd0);
`endif
      chk("cnt_adr", imem_adr, 32'h300);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
